// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - read-side handshake bundle between consumer, FIFO RAM port and read controller
interface fifo_read_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              citaj;
  logic              citaj_vise;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W-1:0] raddr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              burst_busy;
  logic              burst_done;
  logic [ADDR_W:0]   burst_beats;
  logic              underflow;

  modport master (
    output citaj, citaj_vise, wptr,
    input  rptr, raddr, fifo_rd, fifo_empty, fifo_count,
    input  burst_busy, burst_done, burst_beats, underflow
  );

  modport slave (
    input  citaj, citaj_vise, wptr,
    output rptr, raddr, fifo_rd, fifo_empty, fifo_count,
    output burst_busy, burst_done, burst_beats, underflow
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read pointer with wrap bit, single/burst read FSM and sticky underflow
module fifo_read_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst_edge,
  fifo_read_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] rptr_q;
  logic [ADDR_W:0] beat_cnt, beat_cnt_nxt, beat_inc;
  logic [ADDR_W:0] beats_q, beats_nxt;
  logic            busy_q, done_q, done_nxt, uf_q, uf_nxt;
  logic            rd, empty;

  // Wrap bit makes equal pointers mean empty; full is the write side's concern
  assign empty          = (rptr_q == bus.wptr);
  assign beat_inc       = beat_cnt + ONE;
  assign bus.fifo_empty = empty;
  assign bus.fifo_count = bus.wptr - rptr_q;
  assign bus.fifo_rd    = rd;
  assign bus.rptr       = rptr_q;
  assign bus.raddr      = rptr_q[ADDR_W-1:0];
  assign bus.burst_busy = busy_q;
  assign bus.burst_done = done_q;
  assign bus.burst_beats = beats_q;
  assign bus.underflow  = uf_q;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    beats_nxt    = beats_q;
    done_nxt     = 1'b0;
    uf_nxt       = uf_q;
    rd           = 1'b0;
    case (state)
      IDLE: begin
        if (bus.citaj || bus.citaj_vise) begin
          if (empty) uf_nxt = 1'b1;
          else       rd     = 1'b1;
        end
        // Burst wins over a simultaneous single read; first beat goes out now
        if (bus.citaj_vise && !empty) begin
          beat_cnt_nxt = ONE;
          if (LEN == ONE) begin
            done_nxt  = 1'b1;
            beats_nxt = ONE;
          end else begin
            state_nxt = BURST;
          end
        end
      end
      BURST: begin
        if (empty) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          beats_nxt = beat_cnt;
        end else begin
          rd           = 1'b1;
          beat_cnt_nxt = beat_inc;
          if (beat_inc == LEN) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            beats_nxt = LEN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      state    <= IDLE;
      rptr_q   <= '0;
      beat_cnt <= '0;
      beats_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      beats_q  <= beats_nxt;
      busy_q   <= (state_nxt == BURST);
      done_q   <= done_nxt;
      uf_q     <= uf_nxt;
      if (rd) rptr_q <= rptr_q + ONE;
    end
  end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - scoreboard bench for fifo_read_ctrl with directed and random traffic
module tb_fifo_read_ctrl;
  localparam int AW   = 4;
  localparam int BL   = 4;
  localparam int PMOD = 1 << (AW + 1);
  localparam int DEP  = 1 << AW;

  typedef struct {
    int rd, raddr, rptr, empty, count, busy, done, beats, uf, cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_edge = 1'b1;
  fifo_read_ctrl_if #(.ADDR_W(AW)) bus();

  fifo_read_ctrl #(.ADDR_W(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_edge(rst_edge), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cur_wp = 0;

  // Reference: occupancy is pointer distance; a burst is "beats still owed"
  int m_rptr = 0, m_left = 0, m_taken = 0, m_done = 0, m_beats = 0, m_uf = 0;

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rptr = 0; m_left = 0; m_taken = 0; m_done = 0; m_beats = 0; m_uf = 0;
  endtask

  task automatic model_cycle(input int ci, input int cv, input int wp, input bit in_reset);
    exp_t e;
    int empty, rd, dn;
    empty   = (wp == m_rptr) ? 1 : 0;
    e.rptr  = m_rptr;
    e.raddr = m_rptr % DEP;
    e.empty = empty;
    e.count = (wp - m_rptr + PMOD) % PMOD;
    e.busy  = (m_left > 0) ? 1 : 0;
    e.done  = m_done;
    e.beats = m_beats;
    e.uf    = m_uf;
    e.cyc   = cyc;
    dn = 0;
    if (m_left == 0) begin
      rd = (empty == 0 && (ci != 0 || cv != 0)) ? 1 : 0;
      if ((ci != 0 || cv != 0) && empty != 0) m_uf = 1;
      if (cv != 0 && empty == 0) begin
        m_taken = 1;
        if (BL == 1) begin dn = 1; m_beats = 1; end
        else m_left = BL - 1;
      end
    end else begin
      rd = (empty == 0) ? 1 : 0;
      if (empty != 0) begin
        m_left = 0; dn = 1; m_beats = m_taken;
      end else begin
        m_taken++; m_left--;
        if (m_left == 0) begin dn = 1; m_beats = BL; end
      end
    end
    e.rd = rd;
    q.push_back(e);
    if (in_reset) model_reset();
    else begin
      m_done = dn;
      m_rptr = (m_rptr + rd) % PMOD;
    end
  endtask

  task automatic step(input int ci, input int cv, input int wp);
    @(posedge clk); #1;
    cyc++;
    cur_wp = wp % PMOD;
    bus.citaj = ci[0]; bus.citaj_vise = cv[0]; bus.wptr = cur_wp[AW:0];
    model_cycle(ci, cv, cur_wp, 1'b0);
  endtask

  // Asynchronous reset mid-cycle, checked while held and in the cycle it releases
  task automatic rst_cycle();
    @(posedge clk); #1;
    cyc++;
    rst_edge = 1'b1;
    cur_wp = 0;
    bus.citaj = 1'b0; bus.citaj_vise = 1'b0; bus.wptr = '0;
    model_reset();
    model_cycle(0, 0, 0, 1'b1);
    @(posedge clk); #1;
    cyc++;
    rst_edge = 1'b0;
    model_cycle(0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fifo_rd",     e.cyc, int'(bus.fifo_rd),     e.rd);
      chk("raddr",       e.cyc, int'(bus.raddr),       e.raddr);
      chk("rptr",        e.cyc, int'(bus.rptr),        e.rptr);
      chk("fifo_empty",  e.cyc, int'(bus.fifo_empty),  e.empty);
      chk("fifo_count",  e.cyc, int'(bus.fifo_count),  e.count);
      chk("burst_busy",  e.cyc, int'(bus.burst_busy),  e.busy);
      chk("burst_done",  e.cyc, int'(bus.burst_done),  e.done);
      chk("burst_beats", e.cyc, int'(bus.burst_beats), e.beats);
      chk("underflow",   e.cyc, int'(bus.underflow),   e.uf);
    end
  end

  initial begin
    int cnt;
    bus.citaj = 1'b0; bus.citaj_vise = 1'b0; bus.wptr = '0;
    model_reset();

    // Reset with wptr = 0
    rst_cycle();
    step(0, 0, 0);

    // Single reads past empty
    rst_cycle();
    for (int i = 0; i < 4; i++) step(1, 0, 3);
    step(0, 0, 3);

    // Full burst
    rst_cycle();
    step(0, 1, 6);
    for (int i = 0; i < 5; i++) step(0, 0, 6);

    // Early termination
    rst_cycle();
    step(0, 1, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 2);

    // Wrap-around of the RAM address
    rst_cycle();
    for (int i = 0; i < 15; i++) step(1, 0, 15);
    for (int i = 0; i < 3; i++) step(1, 0, 17);
    step(0, 0, 17);

    // Priority then reset mid-burst
    rst_cycle();
    step(1, 1, 8);
    step(1, 0, 8);
    rst_cycle();
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Back-to-back bursts, second accepted in the burst_done cycle
    rst_cycle();
    step(0, 1, 9);
    for (int i = 0; i < 3; i++) step(0, 0, 9);
    step(0, 1, 9);
    for (int i = 0; i < 5; i++) step(0, 0, 9);

    // Random traffic with a write side that never overfills
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst_cycle();
      else begin
        cnt = (cur_wp - m_rptr + PMOD) % PMOD;
        if ($urandom_range(0, 1) == 1 && cnt < DEP) cur_wp = (cur_wp + 1) % PMOD;
        step(($urandom_range(0, 3) == 0) ? 1 : 0,
             ($urandom_range(0, 9) == 0) ? 1 : 0, cur_wp);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
